// File: rtl/capture_pkg.sv
// capture_pkg: shared types and constants for the out_capture response buffer.
//   cap_state_t : FSM state encoding (IDLE, CAPTURE, DONE)
//   ERR_W       : width of the mismatch counter
//   ERR_MAX     : saturation value of the mismatch counter
package capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } cap_state_t;

    localparam int               ERR_W   = 16;
    localparam logic [ERR_W-1:0] ERR_MAX = 16'hFFFF;

endpackage

// File: rtl/capture_mem.sv
// capture_mem: DEPTH x WIDTH register array, one write port, one registered
// read port. Array contents are not reset; only the read register is.
//   clk    in            clock
//   reset  in            synchronous active-low reset (clears rdata)
//   we     in            write enable
//   waddr  in  AW        write address
//   wdata  in  WIDTH     write data
//   re     in            read enable
//   raddr  in  AW        read address
//   rdata  out WIDTH     registered read data
module capture_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/out_capture.sv
// out_capture: records a datapath unit's output words, one entry per accepted
// strobe, and replays them sequentially (wrapping) once capture is finished.
// Optional compare of each captured word against an expected word is enabled
// by defining CAPTURE_COMPARE_EN; otherwise errors is held at 0.
//
// Ports:
//   clk          in            clock, rising edge
//   reset        in            synchronous active-low reset
//   start        in            clear buffer/counters, begin capture
//   stop         in            end capture early
//   cap_valid    in            cap_data/cap_expected valid
//   cap_ready    out           capture accepted this cycle when valid
//   cap_data     in  WIDTH     word to record
//   cap_expected in  WIDTH     expected word (compare build only)
//   rd_req       in            request next stored entry
//   rd_valid     out           rd_data holds an entry
//   rd_data      out WIDTH     entry read back
//   count        out CW        entries stored (0..DEPTH)
//   errors       out 16        saturating mismatch count
//   done         out           capture finished, buffer readable
//
// State | meaning
// IDLE    | waiting for start
// CAPTURE | accepting captures until DEPTH entries or stop
// DONE    | buffer frozen, rd_req replays entries
module out_capture
    import capture_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             cap_valid,
    output logic             cap_ready,
    input  logic [WIDTH-1:0] cap_data,
    input  logic [WIDTH-1:0] cap_expected,
    input  logic             rd_req,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic [ERR_W-1:0] errors,
    output logic             done
);

    cap_state_t       r_state;
    logic             r_cap_ready;
    logic             r_done;
    logic             r_rd_valid;
    logic [CW-1:0]    r_count;
    logic [ERR_W-1:0] r_errors;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;

    logic             w_wr_en;
    logic             w_rd_fire;
    logic             w_mismatch;

    // start and reset both pre-empt any write or read in the same cycle.
    assign w_wr_en   = reset && !start && (r_state == CAPTURE) && cap_valid;
    assign w_rd_fire = reset && !start && (r_state == DONE) && rd_req
                       && (r_count != '0);

`ifdef CAPTURE_COMPARE_EN
    // 4-state inequality so X/Z on either side counts as a mismatch.
    assign w_mismatch = (cap_data !== cap_expected);
`else
    logic w_unused_expected;
    assign w_unused_expected = ^cap_expected;
    assign w_mismatch        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cap_ready <= 1'b0;
            r_done      <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_count     <= '0;
            r_errors    <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
        end else if (start) begin
            r_state     <= CAPTURE;
            r_cap_ready <= 1'b1;
            r_done      <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_count     <= '0;
            r_errors    <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
        end else begin
            r_rd_valid <= w_rd_fire;
            case (r_state)
                IDLE: begin
                    r_cap_ready <= 1'b0;
                    r_done      <= 1'b0;
                end
                CAPTURE: begin
                    if (cap_valid) begin
                        r_wr_ptr <= r_wr_ptr + AW'(1);
                        r_count  <= r_count + CW'(1);
                        if (w_mismatch && (r_errors != ERR_MAX)) begin
                            r_errors <= r_errors + ERR_W'(1);
                        end
                    end
                    // Full means this accept is entry DEPTH; stop with an
                    // accept still stores the entry first.
                    if ((cap_valid && (r_count == CW'(DEPTH - 1))) || stop) begin
                        r_state     <= DONE;
                        r_cap_ready <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                DONE: begin
                    if (w_rd_fire) begin
                        if ({1'b0, r_rd_ptr} == (r_count - CW'(1))) begin
                            r_rd_ptr <= '0;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + AW'(1);
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cap_ready <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    capture_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (w_wr_en),
        .waddr (r_wr_ptr),
        .wdata (cap_data),
        .re    (w_rd_fire),
        .raddr (r_rd_ptr),
        .rdata (rd_data)
    );

    assign cap_ready = r_cap_ready;
    assign rd_valid  = r_rd_valid;
    assign count     = r_count;
    assign errors    = r_errors;
    assign done      = r_done;

endmodule
